pipe_control_unit: RTL and testbench

- Next-generation MIPS ID-stage control unit.
- Decodes opcode and funct into registered ID/EX control bundles for the EX, MEM and WB stages.
- Adds an extended opcode set, a parametrised ALUOp width, load-use hazard detection with bubble insertion, external stall/flush, and illegal-opcode reporting.
- Sits between the IF/ID register and the ID/EX pipeline register; its outputs are the ID/EX control fields.

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/pipe_control_unit_if.sv | 43 ++++
 rtl/ctrl_decoder.sv | 84 ++++++++
 rtl/pipe_control_unit.sv | 106 ++++++++++
 tb/tb_pipe_control_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage control unit: opcodes, ALUOp values and
// the bit layout of the control bundle carried into ID/EX.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_FUNCT = 3'd2;
  localparam logic [2:0] ALUOP_AND   = 3'd3;
  localparam logic [2:0] ALUOP_OR    = 3'd4;
  localparam logic [2:0] ALUOP_SLT   = 3'd5;
  localparam logic [2:0] ALUOP_LUI   = 3'd6;

  localparam int CB_REGWRITE  = 0;
  localparam int CB_MEMTOREG  = 1;
  localparam int CB_BRANCH    = 2;
  localparam int CB_BRANCHNE  = 3;
  localparam int CB_MEMREAD   = 4;
  localparam int CB_MEMWRITE  = 5;
  localparam int CB_REGDST    = 6;
  localparam int CB_ALUSRC    = 7;
  localparam int CB_EXTOP     = 8;
  localparam int CB_JUMP      = 9;
  localparam int CB_LINK      = 10;
  localparam int CB_ALUOP_LSB = 11;
  localparam int CB_W         = 14;

  typedef logic [CB_W-1:0] ctrl_bundle_t;

  // Instructions whose rt field is a source operand (not a destination).
  function automatic logic uses_rt_f(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/pipe_control_unit_if.sv
// IF/ID-side inputs and ID/EX control outputs of the control unit.
interface pipe_control_unit_if #(
  parameter int ALUOP_W = 3
);
  logic               instr_valid;
  logic [5:0]         opcode;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic               stall_in;
  logic               flush_in;
  logic               wb_RegWrite_out;
  logic               wb_MemtoReg_out;
  logic               m_Branch_out;
  logic               m_BranchNe_out;
  logic               m_MemRead_out;
  logic               m_MemWrite_out;
  logic               ex_RegDst_out;
  logic               ex_ALUSrc_out;
  logic               ex_ExtOp_out;
  logic [ALUOP_W-1:0] ex_ALUOp_out;
  logic               id_Jump_out;
  logic               wb_Link_out;
  logic               ctrl_valid_out;
  logic               hazard_stall_out;
  logic               illegal_op_out;
  logic               illegal_sticky_out;

  modport slave (
    input  instr_valid, opcode, rs, rt, stall_in, flush_in,
    output wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_BranchNe_out,
           m_MemRead_out, m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out,
           ex_ExtOp_out, ex_ALUOp_out, id_Jump_out, wb_Link_out,
           ctrl_valid_out, hazard_stall_out, illegal_op_out, illegal_sticky_out
  );

  modport master (
    output instr_valid, opcode, rs, rt, stall_in, flush_in,
    input  wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_BranchNe_out,
           m_MemRead_out, m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out,
           ex_ExtOp_out, ex_ALUOp_out, id_Jump_out, wb_Link_out,
           ctrl_valid_out, hazard_stall_out, illegal_op_out, illegal_sticky_out
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Combinational opcode -> control bundle decode with legality and rt-use flags.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  output ctrl_bundle_t bundle,
  output logic         legal,
  output logic         uses_rt
);

  always_comb begin
    bundle  = '0;
    legal   = 1'b1;
    uses_rt = uses_rt_f(opcode);
    case (opcode)
      OP_RTYPE: begin
        bundle[CB_REGWRITE]        = 1'b1;
        bundle[CB_REGDST]          = 1'b1;
        bundle[CB_ALUOP_LSB +: 3]  = ALUOP_FUNCT;
      end
      OP_LW: begin
        bundle[CB_REGWRITE] = 1'b1;
        bundle[CB_MEMTOREG] = 1'b1;
        bundle[CB_MEMREAD]  = 1'b1;
        bundle[CB_ALUSRC]   = 1'b1;
        bundle[CB_EXTOP]    = 1'b1;
        bundle[CB_ALUOP_LSB +: 3] = ALUOP_ADD;
      end
      OP_SW: begin
        bundle[CB_MEMWRITE] = 1'b1;
        bundle[CB_ALUSRC]   = 1'b1;
        bundle[CB_EXTOP]    = 1'b1;
        bundle[CB_ALUOP_LSB +: 3] = ALUOP_ADD;
      end
      OP_BEQ: begin
        bundle[CB_BRANCH] = 1'b1;
        bundle[CB_EXTOP]  = 1'b1;
        bundle[CB_ALUOP_LSB +: 3] = ALUOP_SUB;
      end
      OP_BNE: begin
        bundle[CB_BRANCHNE] = 1'b1;
        bundle[CB_EXTOP]    = 1'b1;
        bundle[CB_ALUOP_LSB +: 3] = ALUOP_SUB;
      end
      OP_ADDI: begin
        bundle[CB_REGWRITE] = 1'b1;
        bundle[CB_ALUSRC]   = 1'b1;
        bundle[CB_EXTOP]    = 1'b1;
        bundle[CB_ALUOP_LSB +: 3] = ALUOP_ADD;
      end
      OP_ANDI: begin
        bundle[CB_REGWRITE] = 1'b1;
        bundle[CB_ALUSRC]   = 1'b1;
        bundle[CB_ALUOP_LSB +: 3] = ALUOP_AND;
      end
      OP_ORI: begin
        bundle[CB_REGWRITE] = 1'b1;
        bundle[CB_ALUSRC]   = 1'b1;
        bundle[CB_ALUOP_LSB +: 3] = ALUOP_OR;
      end
      OP_SLTI: begin
        bundle[CB_REGWRITE] = 1'b1;
        bundle[CB_ALUSRC]   = 1'b1;
        bundle[CB_EXTOP]    = 1'b1;
        bundle[CB_ALUOP_LSB +: 3] = ALUOP_SLT;
      end
      OP_LUI: begin
        bundle[CB_REGWRITE] = 1'b1;
        bundle[CB_ALUSRC]   = 1'b1;
        bundle[CB_ALUOP_LSB +: 3] = ALUOP_LUI;
      end
      OP_J: begin
        bundle[CB_JUMP] = 1'b1;
      end
      OP_JAL: begin
        bundle[CB_REGWRITE] = 1'b1;
        bundle[CB_JUMP]     = 1'b1;
        bundle[CB_LINK]     = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_control_unit.sv
// ID-stage control unit: registers the decoded bundle into ID/EX and applies
// reset/flush/stall/load-use/valid priority plus illegal-opcode reporting.
module pipe_control_unit
  import ctrl_pkg::*;
#(
  parameter int B         = 32,
  parameter int ALUOP_W   = 3,
  parameter bit HAZARD_EN = 1'b1
) (
  input logic                 clk,
  input logic                 reset_n,
  pipe_control_unit_if.slave  bus
);

  if (ALUOP_W < 3 || B < 32) begin : g_bad_param
    $error("pipe_control_unit: ALUOP_W must be >= 3 and B >= 32");
  end

  ctrl_bundle_t dec_bundle;
  logic         dec_legal;
  logic         dec_uses_rt;

  ctrl_decoder u_dec (
    .opcode  (bus.opcode),
    .bundle  (dec_bundle),
    .legal   (dec_legal),
    .uses_rt (dec_uses_rt)
  );

  ctrl_bundle_t bundle_q, bundle_d;
  logic         valid_q, valid_d;
  logic [4:0]   ex_rt_q, ex_rt_d;
  logic         illegal_q, illegal_d;
  logic         sticky_q, sticky_d;
  logic         hazard;

  // Load in EX whose destination feeds a source of the instruction in ID.
  always_comb begin
    hazard = HAZARD_EN && bus.instr_valid && valid_q && bundle_q[CB_MEMREAD] &&
             (ex_rt_q != 5'd0) &&
             ((ex_rt_q == bus.rs) || (dec_uses_rt && (ex_rt_q == bus.rt)));
  end

  always_comb begin
    bundle_d  = bundle_q;
    valid_d   = valid_q;
    ex_rt_d   = ex_rt_q;
    illegal_d = illegal_q;
    sticky_d  = sticky_q;
    if (bus.flush_in) begin
      bundle_d  = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (bus.stall_in) begin
      // hold everything, including the pulse and ex_rt
    end else if (hazard || !bus.instr_valid) begin
      bundle_d  = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!dec_legal) begin
      bundle_d  = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b1;
      sticky_d  = 1'b1;
    end else begin
      bundle_d  = dec_bundle;
      valid_d   = 1'b1;
      ex_rt_d   = bus.rt;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bundle_q  <= '0;
      valid_q   <= 1'b0;
      ex_rt_q   <= 5'd0;
      illegal_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      bundle_q  <= bundle_d;
      valid_q   <= valid_d;
      ex_rt_q   <= ex_rt_d;
      illegal_q <= illegal_d;
      sticky_q  <= sticky_d;
    end
  end

  assign bus.wb_RegWrite_out    = bundle_q[CB_REGWRITE];
  assign bus.wb_MemtoReg_out    = bundle_q[CB_MEMTOREG];
  assign bus.m_Branch_out       = bundle_q[CB_BRANCH];
  assign bus.m_BranchNe_out     = bundle_q[CB_BRANCHNE];
  assign bus.m_MemRead_out      = bundle_q[CB_MEMREAD];
  assign bus.m_MemWrite_out     = bundle_q[CB_MEMWRITE];
  assign bus.ex_RegDst_out      = bundle_q[CB_REGDST];
  assign bus.ex_ALUSrc_out      = bundle_q[CB_ALUSRC];
  assign bus.ex_ExtOp_out       = bundle_q[CB_EXTOP];
  assign bus.ex_ALUOp_out       = ALUOP_W'(bundle_q[CB_ALUOP_LSB +: 3]);
  assign bus.id_Jump_out        = bundle_q[CB_JUMP];
  assign bus.wb_Link_out        = bundle_q[CB_LINK];
  assign bus.ctrl_valid_out     = valid_q;
  assign bus.hazard_stall_out   = hazard;
  assign bus.illegal_op_out     = illegal_q;
  assign bus.illegal_sticky_out = sticky_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench: a table-driven reference model checked every cycle, plus
// hand-computed literal expectations at key points.
module tb_pipe_control_unit;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_control_unit_if #(.ALUOP_W(3)) bus ();

  pipe_control_unit #(.B(32), .ALUOP_W(3), .HAZARD_EN(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Columns in decode-table order.
  typedef struct packed {
    logic rw, mtr, br, bne, mr, mw, rd, as, ext;
    logic [2:0] alu;
    logic j, l;
  } row_t;

  function automatic logic [14:0] table_row(input logic [5:0] op);
    case (op)
      6'b000000: return {1'b1, 14'b100000100_010_00};
      6'b100011: return {1'b1, 14'b110010011_000_00};
      6'b101011: return {1'b1, 14'b000001011_000_00};
      6'b000100: return {1'b1, 14'b001000001_001_00};
      6'b000101: return {1'b1, 14'b000100001_001_00};
      6'b001000: return {1'b1, 14'b100000011_000_00};
      6'b001100: return {1'b1, 14'b100000010_011_00};
      6'b001101: return {1'b1, 14'b100000010_100_00};
      6'b001010: return {1'b1, 14'b100000011_101_00};
      6'b001111: return {1'b1, 14'b100000010_110_00};
      6'b000010: return {1'b1, 14'b000000000_000_10};
      6'b000011: return {1'b1, 14'b100000000_000_11};
      default:   return 15'd0;
    endcase
  endfunction

  row_t       m_row;
  logic       m_valid, m_ill, m_sticky, m_hz;
  logic [4:0] m_rt;
  logic [14:0] cur;

  always_comb begin
    cur = table_row(bus.opcode);
    m_hz = bus.instr_valid && m_valid && m_row.mr && (m_rt != 5'd0) &&
           ((m_rt == bus.rs) ||
            ((bus.opcode inside {6'b000000, 6'b101011, 6'b000100, 6'b000101}) &&
             (m_rt == bus.rt)));
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      m_row <= '0; m_valid <= 1'b0; m_rt <= 5'd0; m_ill <= 1'b0; m_sticky <= 1'b0;
    end else if (bus.flush_in) begin
      m_row <= '0; m_valid <= 1'b0; m_ill <= 1'b0;
    end else if (bus.stall_in) begin
      m_row <= m_row;
    end else if (m_hz || !bus.instr_valid) begin
      m_row <= '0; m_valid <= 1'b0; m_ill <= 1'b0;
    end else if (!cur[14]) begin
      m_row <= '0; m_valid <= 1'b0; m_ill <= 1'b1; m_sticky <= 1'b1;
    end else begin
      m_row <= cur[13:0]; m_valid <= 1'b1; m_rt <= bus.rt; m_ill <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("RegWrite", 32'(bus.wb_RegWrite_out), 32'(m_row.rw));
      check("MemtoReg", 32'(bus.wb_MemtoReg_out), 32'(m_row.mtr));
      check("Branch",   32'(bus.m_Branch_out),    32'(m_row.br));
      check("BranchNe", 32'(bus.m_BranchNe_out),  32'(m_row.bne));
      check("MemRead",  32'(bus.m_MemRead_out),   32'(m_row.mr));
      check("MemWrite", 32'(bus.m_MemWrite_out),  32'(m_row.mw));
      check("RegDst",   32'(bus.ex_RegDst_out),   32'(m_row.rd));
      check("ALUSrc",   32'(bus.ex_ALUSrc_out),   32'(m_row.as));
      check("ExtOp",    32'(bus.ex_ExtOp_out),    32'(m_row.ext));
      check("ALUOp",    32'(bus.ex_ALUOp_out),    32'(m_row.alu));
      check("Jump",     32'(bus.id_Jump_out),     32'(m_row.j));
      check("Link",     32'(bus.wb_Link_out),     32'(m_row.l));
      check("valid",    32'(bus.ctrl_valid_out),  32'(m_valid));
      check("hazard",   32'(bus.hazard_stall_out), 32'(m_hz));
      check("illegal",  32'(bus.illegal_op_out),  32'(m_ill));
      check("sticky",   32'(bus.illegal_sticky_out), 32'(m_sticky));
    end
  end

  // Present one input vector for one edge; returns at the following negedge.
  task automatic step(input logic iv, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic st = 1'b0, input logic fl = 1'b0,
                      input logic rn = 1'b1, input int exp_hz = -1);
    #1;
    bus.instr_valid = iv; bus.opcode = op; bus.rs = rs; bus.rt = rt;
    bus.stall_in = st; bus.flush_in = fl; reset_n = rn;
    #1;
    if (exp_hz >= 0) check("hazard_lit", 32'(bus.hazard_stall_out), 32'(exp_hz));
    @(negedge clk);
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  logic [5:0] sweep [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                             6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111,
                             6'b000010, 6'b000011};

  initial begin
    reset_n = 1'b0;
    bus.instr_valid = 1'b1; bus.opcode = LW; bus.rs = 5'd1; bus.rt = 5'd5;
    bus.stall_in = 1'b0; bus.flush_in = 1'b0;
    @(posedge clk); #1 chk_en = 1'b1;
    @(negedge clk);
    step(1, LW, 1, 5, 0, 0, 0);
    check("rst_valid", 32'(bus.ctrl_valid_out), 32'd0);
    check("rst_memread", 32'(bus.m_MemRead_out), 32'd0);

    step(1, LW, 1, 3);
    check("lw_memread", 32'(bus.m_MemRead_out), 32'd1);
    check("lw_memtoreg", 32'(bus.wb_MemtoReg_out), 32'd1);
    check("lw_aluop", 32'(bus.ex_ALUOp_out), 32'd0);
    check("lw_valid", 32'(bus.ctrl_valid_out), 32'd1);

    foreach (sweep[i]) step(1, sweep[i], 1, 2);
    check("jal_regwrite", 32'(bus.wb_RegWrite_out), 32'd1);
    check("jal_jump", 32'(bus.id_Jump_out), 32'd1);
    check("jal_link", 32'(bus.wb_Link_out), 32'd1);

    // load-use
    step(1, LW, 0, 5);
    step(1, RT, 5, 6, 0, 0, 1, 1);
    check("lu_bubble", 32'(bus.ctrl_valid_out), 32'd0);
    step(1, RT, 5, 6, 0, 0, 1, 0);
    check("lu_redecode", 32'(bus.ctrl_valid_out), 32'd1);
    check("lu_regdst", 32'(bus.ex_RegDst_out), 32'd1);
    step(1, LW, 0, 0);
    step(1, RT, 0, 0, 0, 0, 1, 0);
    check("rt0_valid", 32'(bus.ctrl_valid_out), 32'd1);

    // flush + stall, then stall alone
    step(1, ADDI, 1, 2);
    step(1, RT, 1, 2, 1, 1);
    check("fs_bubble", 32'(bus.ctrl_valid_out), 32'd0);
    step(1, LW, 1, 7);
    for (int k = 0; k < 3; k++) begin
      step(1, RT, 7, 8, 1, 0, 1, 1);
      check("stall_hold_mr", 32'(bus.m_MemRead_out), 32'd1);
    end
    step(1, ADDI, 2, 7, 0, 0, 1, 0);
    check("addi_alusrc", 32'(bus.ex_ALUSrc_out), 32'd1);

    // illegal opcode
    step(1, BAD, 1, 2);
    check("ill_pulse", 32'(bus.illegal_op_out), 32'd1);
    check("ill_bubble", 32'(bus.ctrl_valid_out), 32'd0);
    check("ill_sticky", 32'(bus.illegal_sticky_out), 32'd1);
    step(1, SW, 1, 2, 1);
    check("ill_hold", 32'(bus.illegal_op_out), 32'd1);
    step(0, SW, 1, 2);
    check("iv0_memwrite", 32'(bus.m_MemWrite_out), 32'd0);
    check("iv0_illegal", 32'(bus.illegal_op_out), 32'd0);
    check("iv0_sticky", 32'(bus.illegal_sticky_out), 32'd1);

    // hazard beats illegal
    step(1, LW, 1, 4);
    step(1, BAD, 4, 2, 0, 0, 1, 1);
    check("hz_ill_flag", 32'(bus.illegal_op_out), 32'd0);
    step(1, BAD, 4, 2);
    check("ill_repres", 32'(bus.illegal_op_out), 32'd1);

    // reset during stall
    step(1, LW, 0, 5);
    step(1, RT, 5, 6, 1, 0, 1, 1);
    step(1, RT, 5, 6, 1, 0, 0);
    check("rst_stall_valid", 32'(bus.ctrl_valid_out), 32'd0);
    check("rst_sticky", 32'(bus.illegal_sticky_out), 32'd0);
    step(1, RT, 5, 6, 0, 0, 1, 0);
    check("post_rst_valid", 32'(bus.ctrl_valid_out), 32'd1);

    step(0, RT, 0, 0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
